mdio_master: RTL and testbench

- IEEE 802.3 Clause 22 MDIO management master that drives the shared PHY control pins `mdc`/`mdio`.
- Sits beside the MAC in the top level. It takes single register read/write commands from a controller (reset-time PHY configuration, link-status polling) and returns one response per command.
- The top level owns the `mdio` tri-state buffer. This block exposes split `mdio_o`, `mdio_oe` and `mdio_i`.

---
 rtl/mdio_pkg.sv | 33 +++
 rtl/mdio_if.sv | 23 ++
 rtl/mdio_clkgen.sv | 44 ++++
 rtl/mdio_master.sv | 140 ++++++++++++++
 tb/tb_mdio_master.sv | 269 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/mdio_pkg.sv
// Shared constants, state encoding and frame builder for the Clause 22 MDIO master.
package mdio_pkg;

   localparam logic [1:0] MDIO_ST       = 2'b01;
   localparam logic [1:0] MDIO_OP_WRITE = 2'b01;
   localparam logic [1:0] MDIO_OP_READ  = 2'b10;

   localparam int MDIO_FRAME_BITS = 64;
   localparam int MDIO_TA_BIT     = 46;
   localparam int MDIO_DATA_BIT   = 48;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      TAIL  = 2'd2,
      RESP  = 2'd3
   } mdio_state_t;

   // Read frames carry all-ones in TA/data; those bits are never driven.
   function automatic logic [63:0] mdio_frame(input logic        write,
                                              input logic [4:0]  phy_addr,
                                              input logic [4:0]  reg_addr,
                                              input logic [15:0] wdata);
      logic [1:0]  op;
      logic [1:0]  ta;
      logic [15:0] data;
      op   = write ? MDIO_OP_WRITE : MDIO_OP_READ;
      ta   = write ? 2'b10 : 2'b11;
      data = write ? wdata : 16'hFFFF;
      return {32'hFFFF_FFFF, MDIO_ST, op, phy_addr, reg_addr, ta, data};
   endfunction

endpackage

// File: rtl/mdio_if.sv
// Command/response channel between a management controller and mdio_master.
// A command transfers on a rising clk with cmd_valid && cmd_ready; rsp_valid is a one-cycle pulse with no backpressure.
interface mdio_if;
   logic        cmd_valid;
   logic        cmd_ready;
   logic        cmd_write;
   logic [4:0]  cmd_phy_addr;
   logic [4:0]  cmd_reg_addr;
   logic [15:0] cmd_wdata;
   logic        rsp_valid;
   logic [15:0] rsp_rdata;
   logic        rsp_err;

   modport master (
      output cmd_valid, cmd_write, cmd_phy_addr, cmd_reg_addr, cmd_wdata,
      input  cmd_ready, rsp_valid, rsp_rdata, rsp_err
   );

   modport slave (
      input  cmd_valid, cmd_write, cmd_phy_addr, cmd_reg_addr, cmd_wdata,
      output cmd_ready, rsp_valid, rsp_rdata, rsp_err
   );
endinterface

// File: rtl/mdio_clkgen.sv
// MDC generator: low then high for CLK_DIV clks each, with strobes on the clk where mdc will rise/fall.
module mdio_clkgen #(
   parameter int CLK_DIV = 5
) (
   input  logic clk,
   input  logic rst_n,
   input  logic en,
   input  logic gate,
   output logic mdc,
   output logic fall_en,
   output logic rise_en
);

   localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [CW-1:0] CNT_MAX = CW'(CLK_DIV - 1);

   logic [CW-1:0] cnt;
   logic          phase;
   logic          wrap;

   assign wrap    = en && (cnt == CNT_MAX);
   assign rise_en = wrap && !phase;
   assign fall_en = wrap && phase;

   // phase keeps timing through the idle tail bit while gate holds the pin low.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt   <= '0;
         phase <= 1'b0;
         mdc   <= 1'b0;
      end else if (!en) begin
         cnt   <= '0;
         phase <= 1'b0;
         mdc   <= 1'b0;
      end else if (wrap) begin
         cnt   <= '0;
         phase <= ~phase;
         mdc   <= ~phase & gate;
      end else begin
         cnt   <= cnt + CW'(1);
      end
   end

endmodule

// File: rtl/mdio_master.sv
// Clause 22 MDIO master: shifts one 64-bit frame per command and returns one response pulse.
module mdio_master
   import mdio_pkg::*;
#(
   parameter int CLK_DIV = 5
) (
   input  logic       clk,
   input  logic       rst_n,
   mdio_if.slave      bus,
   output logic       mdc,
   output logic       mdio_o,
   output logic       mdio_oe,
   input  logic       mdio_i,
   output logic [1:0] dbg_state
);

   localparam logic [1:0] S_IDLE  = IDLE;
   localparam logic [1:0] S_SHIFT = SHIFT;
   localparam logic [1:0] S_TAIL  = TAIL;
   localparam logic [1:0] S_RESP  = RESP;

   logic [1:0]  state;
   logic        start;
   logic        is_write;
   logic [63:0] shreg;
   logic [5:0]  bit_cnt;
   logic [5:0]  next_idx;
   logic        next_oe;
   logic [15:0] rd_shift;
   logic        rd_err;
   logic        sync1, sync2;
   logic        accept;
   logic        clk_en;
   logic        clk_gate;
   logic        fall_en;
   logic        rise_en;

   assign accept    = bus.cmd_valid && bus.cmd_ready;
   assign clk_en    = ((state == S_SHIFT) && !start) || (state == S_TAIL);
   assign clk_gate  = (state == S_SHIFT);
   assign next_idx  = bit_cnt + 6'd1;
   assign next_oe   = is_write || (next_idx < 6'(MDIO_TA_BIT));
   assign dbg_state = state;

   mdio_clkgen #(.CLK_DIV(CLK_DIV)) u_clkgen (
      .clk     (clk),
      .rst_n   (rst_n),
      .en      (clk_en),
      .gate    (clk_gate),
      .mdc     (mdc),
      .fall_en (fall_en),
      .rise_en (rise_en)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1 <= 1'b1;
         sync2 <= 1'b1;
      end else begin
         sync1 <= mdio_i;
         sync2 <= sync1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= S_IDLE;
         start         <= 1'b0;
         is_write      <= 1'b0;
         shreg         <= '1;
         bit_cnt       <= '0;
         rd_shift      <= '0;
         rd_err        <= 1'b0;
         mdio_o        <= 1'b1;
         mdio_oe       <= 1'b0;
         bus.cmd_ready <= 1'b0;
         bus.rsp_valid <= 1'b0;
         bus.rsp_rdata <= '0;
         bus.rsp_err   <= 1'b0;
      end else begin
         bus.rsp_valid <= 1'b0;
         case (state)
            S_IDLE, S_RESP: begin
               bus.cmd_ready <= 1'b1;
               state         <= S_IDLE;
               if (accept) begin
                  state         <= S_SHIFT;
                  start         <= 1'b1;
                  bus.cmd_ready <= 1'b0;
                  is_write      <= bus.cmd_write;
                  shreg         <= mdio_frame(bus.cmd_write, bus.cmd_phy_addr,
                                              bus.cmd_reg_addr, bus.cmd_wdata);
               end
            end
            S_SHIFT: begin
               if (start) begin
                  // Bit 0 is always preamble, driven one clk after acceptance.
                  start    <= 1'b0;
                  bit_cnt  <= '0;
                  mdio_oe  <= 1'b1;
                  mdio_o   <= shreg[63];
                  shreg    <= {shreg[62:0], 1'b1};
                  rd_shift <= '0;
                  rd_err   <= 1'b0;
               end else begin
                  if (rise_en && !is_write) begin
                     if (bit_cnt == 6'(MDIO_TA_BIT + 1))
                        rd_err <= sync2;
                     if (bit_cnt >= 6'(MDIO_DATA_BIT))
                        rd_shift <= {rd_shift[14:0], sync2};
                  end
                  if (fall_en) begin
                     if (bit_cnt == 6'(MDIO_FRAME_BITS - 1)) begin
                        state   <= S_TAIL;
                        mdio_oe <= 1'b0;
                        mdio_o  <= 1'b1;
                     end else begin
                        bit_cnt <= next_idx;
                        mdio_oe <= next_oe;
                        mdio_o  <= next_oe ? shreg[63] : 1'b1;
                        shreg   <= {shreg[62:0], 1'b1};
                     end
                  end
               end
            end
            S_TAIL: begin
               if (fall_en) begin
                  state         <= S_RESP;
                  bus.rsp_valid <= 1'b1;
                  bus.cmd_ready <= 1'b1;
                  bus.rsp_rdata <= is_write ? 16'h0000 : rd_shift;
                  bus.rsp_err   <= !is_write && rd_err;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mdio_master.sv
// Directed bench for mdio_master: CLK_DIV=3 instance with a PHY model, CLK_DIV=5 instance for timing.
module tb_mdio_master;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #20 clk = ~clk;

   mdio_if bus3 ();
   mdio_if bus5 ();
   logic       mdc3, mdio_o3, mdio_oe3, mdio_i3;
   logic       mdc5, mdio_o5, mdio_oe5;
   logic       mdio_i5 = 1'b1;
   logic [1:0] st3, st5;

   mdio_master #(.CLK_DIV(3)) dut3 (
      .clk(clk), .rst_n(rst_n), .bus(bus3.slave), .mdc(mdc3), .mdio_o(mdio_o3),
      .mdio_oe(mdio_oe3), .mdio_i(mdio_i3), .dbg_state(st3)
   );

   mdio_master #(.CLK_DIV(5)) dut5 (
      .clk(clk), .rst_n(rst_n), .bus(bus5.slave), .mdc(mdc5), .mdio_o(mdio_o5),
      .mdio_oe(mdio_oe5), .mdio_i(mdio_i5), .dbg_state(st5)
   );

   int n_checks = 0;
   int n_errors = 0;
   int cyc = 0;

   logic [16:0] exp_q[$];
   int          acc_q[$];
   int          rsp_cnt = 0;
   int          last_acc = 0;
   logic [63:0] cap_o = '0, cap_oe = '0;
   int          ncap = 0;
   int          last_rise = 0;
   logic        mdc3_q = 1'b0;
   logic [16:0] e3;
   int          a3;

   logic        phy_en = 1'b0;
   logic [15:0] phy_data = '0;
   logic [17:0] phy_sr = '1;
   logic        oe3_q = 1'b0, mdcf_q = 1'b0;
   assign mdio_i3 = phy_sr[17];

   int   run5 = 0, rsp5_cnt = 0, acc5 = 0;
   logic mdc5_q = 1'b0, o5_q = 1'b1, have_fall5 = 1'b0;
   int   n, a1;

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h required %0h", name, got, exp);
      end
   endtask

   task automatic send3(input logic w, input logic [4:0] phy, input logic [4:0] ra,
                        input logic [15:0] wd, input logic exp_rsp, input logic [16:0] exp);
      int k = 0;
      @(negedge clk);
      bus3.cmd_valid    = 1'b1;
      bus3.cmd_write    = w;
      bus3.cmd_phy_addr = phy;
      bus3.cmd_reg_addr = ra;
      bus3.cmd_wdata    = wd;
      while (!bus3.cmd_ready && k < 2000) begin
         @(negedge clk);
         k++;
      end
      if (!bus3.cmd_ready) begin
         n_checks++;
         n_errors++;
         $display("FAIL accept_timeout: cmd_ready stayed 0, required 1");
      end else begin
         last_acc = cyc + 1;
         ncap = 0;
         cap_o = '0;
         cap_oe = '0;
         if (exp_rsp) begin
            exp_q.push_back(exp);
            acc_q.push_back(cyc + 1);
         end
      end
      @(posedge clk);
   endtask

   task automatic drop3();
      @(negedge clk);
      bus3.cmd_valid = 1'b0;
   endtask

   task automatic wait_rsp3(input int target);
      int k = 0;
      while (rsp_cnt < target && k < 5000) begin
         @(negedge clk);
         k++;
      end
      chk("rsp_count", rsp_cnt, target);
   endtask

   // Scoreboard/monitor for the CLK_DIV=3 instance.
   initial forever begin
      @(negedge clk);
      if (bus3.rsp_valid) begin
         rsp_cnt++;
         if (exp_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL rsp_unexpected: got rsp_valid=1, required no pending command");
         end else begin
            e3 = exp_q.pop_front();
            a3 = acc_q.pop_front();
            chk("rsp_rdata", bus3.rsp_rdata, e3[15:0]);
            chk("rsp_err", bus3.rsp_err, e3[16]);
            chk("rsp_latency", cyc - a3, 391);
         end
      end
      if (mdc3 && !mdc3_q) begin
         if (ncap > 0) chk("mdc_period", cyc - last_rise, 6);
         last_rise = cyc;
         cap_o  = {cap_o[62:0], mdio_o3};
         cap_oe = {cap_oe[62:0], mdio_oe3};
         ncap++;
      end
      mdc3_q = mdc3;
   end

   // PHY: releases on bit 46 (pull-up), drives 0 on bit 47, then data MSB first on mdc falls.
   initial forever begin
      @(negedge clk);
      if (phy_en && oe3_q && !mdio_oe3) phy_sr = {1'b1, 1'b0, phy_data};
      else if (mdcf_q && !mdc3) phy_sr = {phy_sr[16:0], 1'b1};
      oe3_q  = mdio_oe3;
      mdcf_q = mdc3;
   end

   // Timing monitor for the CLK_DIV=5 instance.
   initial forever begin
      @(negedge clk);
      if (mdc5 != mdc5_q) begin
         if (mdc5) begin
            chk("mdc5_o_stable_at_rise", mdio_o5, o5_q);
            if (have_fall5) chk("mdc5_low_len", run5, 5);
         end else begin
            chk("mdc5_high_len", run5, 5);
            have_fall5 = 1'b1;
         end
         run5 = 1;
      end else begin
         run5++;
      end
      if (bus5.rsp_valid) begin
         rsp5_cnt++;
         chk("rsp5_latency", cyc - acc5, 651);
         chk("rsp5_rdata", bus5.rsp_rdata, 16'h0000);
         chk("rsp5_err", bus5.rsp_err, 1'b0);
      end
      mdc5_q = mdc5;
      o5_q   = mdio_o5;
   end

   initial begin
      bus3.cmd_valid = 1'b0; bus3.cmd_write = 1'b0; bus3.cmd_phy_addr = '0;
      bus3.cmd_reg_addr = '0; bus3.cmd_wdata = '0;
      bus5.cmd_valid = 1'b0; bus5.cmd_write = 1'b0; bus5.cmd_phy_addr = '0;
      bus5.cmd_reg_addr = '0; bus5.cmd_wdata = '0;
      repeat (3) @(negedge clk);
      chk("rst_cmd_ready", bus3.cmd_ready, 1'b0);
      chk("rst_mdc", mdc3, 1'b0);
      chk("rst_mdio_oe", mdio_oe3, 1'b0);
      chk("rst_mdio_o", mdio_o3, 1'b1);
      chk("rst_rsp_valid", bus3.rsp_valid, 1'b0);
      chk("rst_rsp_rdata", bus3.rsp_rdata, 16'h0000);
      chk("rst_rsp_err", bus3.rsp_err, 1'b0);
      chk("rst_state", st3, 2'd0);
      rst_n = 1'b1;
      @(negedge clk);
      chk("ready_after_release", bus3.cmd_ready, 1'b1);

      // Write PHY 1 reg 0 = 0x1140.
      send3(1'b1, 5'd1, 5'd0, 16'h1140, 1'b1, {1'b0, 16'h0000});
      drop3();
      wait_rsp3(1);
      chk("wr_frame", cap_o, 64'hFFFF_FFFF_5082_1140);
      chk("wr_oe", cap_oe, 64'hFFFF_FFFF_FFFF_FFFF);
      chk("wr_bits", ncap, 64);

      // Read PHY 1 reg 1, PHY answers 0x0022.
      phy_en = 1'b1;
      phy_data = 16'h0022;
      send3(1'b0, 5'd1, 5'd1, 16'h0000, 1'b1, {1'b0, 16'h0022});
      drop3();
      wait_rsp3(2);
      chk("rd_frame", cap_o & cap_oe, 64'hFFFF_FFFF_6084_0000);
      chk("rd_oe", cap_oe, 64'hFFFF_FFFF_FFFC_0000);

      // Read with nobody answering: pull-up everywhere.
      phy_en = 1'b0;
      send3(1'b0, 5'd2, 5'd1, 16'h0000, 1'b1, {1'b1, 16'hFFFF});
      drop3();
      wait_rsp3(3);

      // Two back-to-back commands with cmd_valid never dropped.
      phy_en = 1'b1;
      phy_data = 16'h796D;
      send3(1'b1, 5'd1, 5'd4, 16'h01E1, 1'b1, {1'b0, 16'h0000});
      a1 = last_acc;
      send3(1'b0, 5'd1, 5'd1, 16'h0000, 1'b1, {1'b0, 16'h796D});
      chk("held_accept_gap", last_acc - a1, 392);
      drop3();
      wait_rsp3(5);

      // Reset during bit 20 of a write: no response, clean restart.
      send3(1'b1, 5'd3, 5'd0, 16'h8000, 1'b0, 17'h0);
      drop3();
      n = 0;
      while (ncap < 21 && n < 2000) begin
         @(negedge clk);
         n++;
      end
      chk("abort_reached_bit20", ncap, 21);
      #5 rst_n = 1'b0;
      #1;
      chk("abort_mdc", mdc3, 1'b0);
      chk("abort_mdio_oe", mdio_oe3, 1'b0);
      chk("abort_mdio_o", mdio_o3, 1'b1);
      chk("abort_cmd_ready", bus3.cmd_ready, 1'b0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (600) @(negedge clk);
      chk("abort_no_rsp", rsp_cnt, 5);
      send3(1'b1, 5'd1, 5'd0, 16'h1140, 1'b1, {1'b0, 16'h0000});
      drop3();
      wait_rsp3(6);
      chk("post_abort_frame", cap_o, 64'hFFFF_FFFF_5082_1140);
      chk("post_abort_bits", ncap, 64);

      // CLK_DIV=5 write: phase lengths and data stability checked by its monitor.
      @(negedge clk);
      bus5.cmd_valid = 1'b1; bus5.cmd_write = 1'b1; bus5.cmd_phy_addr = 5'd1;
      bus5.cmd_reg_addr = 5'd0; bus5.cmd_wdata = 16'hA5C3;
      n = 0;
      while (!bus5.cmd_ready && n < 100) begin
         @(negedge clk);
         n++;
      end
      acc5 = cyc + 1;
      @(negedge clk);
      bus5.cmd_valid = 1'b0;
      n = 0;
      while (rsp5_cnt < 1 && n < 2000) begin
         @(negedge clk);
         n++;
      end
      chk("rsp5_count", rsp5_cnt, 1);

      repeat (20) @(negedge clk);
      chk("scoreboard_drained", exp_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
